asa_resp_framer: RTL and testbench

ASA_RESP_FRAMER -- requirements
Module: asa_resp_framer

---
 rtl/asa_types.sv | 24 ++
 rtl/asa_resp_fifo.sv | 55 +++++
 rtl/asa_resp_framer.sv | 154 +++++++++++++++
 tb/tb_asa_resp_framer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asa_types.sv
// Shared types for the ASA response framer: header field layout, framer FSM states, response message.
package asa_types;

    localparam int HDR_TAG_LSB = 0;
    localparam int HDR_TAG_W   = 8;
    localparam int HDR_CNT_LSB = 8;
    localparam int HDR_CNT_W   = 12;
    localparam int HDR_SRC_LSB = 20;

    // The dst field sits directly above the src field, whose width follows the tile ID width.
    function automatic int hdr_dst_lsb(input int xy_sz);
        return HDR_SRC_LSB + 2 * xy_sz;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } framer_state_t;

    localparam int ASA_RESP_W = 64;
    typedef logic [ASA_RESP_W-1:0] ASARespMsg;

endpackage

// File: rtl/asa_resp_fifo.sv
// Synchronous FIFO holding whole ASA responses; head entry is readable combinationally.
// Push is refused when full unless a pop happens in the same cycle.
module asa_resp_fifo
    import asa_types::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk_ctrl,
    input  logic                       clk_ctrl_rst_high,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk_ctrl) begin
        if (clk_ctrl_rst_high) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk_ctrl) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/asa_resp_framer.sv
// Frames buffered ASA responses into AXI-stream packets: one header beat then RESP_W/32 payload beats.
// Header beat two edges after a push into an empty FIFO; outputs hold while TREADY is low.
module asa_resp_framer
    import asa_types::*;
#(
    parameter int XY_SZ      = 3,
    parameter int RESP_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_ctrl,
    input  logic                 clk_ctrl_rst_high,
    input  logic [2*XY_SZ-1:0]   HsrcId,
    input  logic [31:0]          header_in,
    input  logic                 header_in_vld,
    input  logic                 resp_val,
    output logic                 resp_rdy,
    input  logic [RESP_W-1:0]    resp_msg,
    output logic                 stream_out_TVALID,
    output logic [31:0]          stream_out_TDATA,
    output logic [3:0]           stream_out_TKEEP,
    output logic                 stream_out_TLAST,
    input  logic                 stream_out_TREADY,
    output logic [15:0]          pkt_count
);

    localparam int ID_W    = 2 * XY_SZ;
    localparam int NW      = RESP_W / 32;
    localparam int WW      = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int DST_LSB = hdr_dst_lsb(XY_SZ);

    framer_state_t     state;
    logic [31:0]       hdr_reg;
    logic              hdr_seen;
    logic [WW-1:0]     w;
    logic [WW-1:0]     w_nxt;
    logic [31:0]       hdr_word;
    logic [31:0]       words [NW];

    logic              push;
    logic              pop;
    logic              more;
    logic [RESP_W-1:0] head_dat;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    // Request fields that the response header never reflects.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{hdr_reg[31:HDR_SRC_LSB+ID_W], hdr_reg[HDR_CNT_LSB +: HDR_CNT_W]};

    assign resp_rdy = !fifo_full;
    assign push     = resp_val && resp_rdy;
    assign pop      = (state == S_DATA) && stream_out_TREADY && stream_out_TLAST;
    assign more     = (fifo_count > CW'(1)) || push;
    assign w_nxt    = w + 1'b1;

    asa_resp_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_ctrl          (clk_ctrl),
        .clk_ctrl_rst_high (clk_ctrl_rst_high),
        .push              (push),
        .push_dat          (resp_msg),
        .pop               (pop),
        .head_dat          (head_dat),
        .full              (fifo_full),
        .empty             (fifo_empty),
        .count             (fifo_count)
    );

    always_comb begin
        for (int i = 0; i < NW; i++) words[i] = head_dat[32*i +: 32];
    end

    // Reply goes back to the requester: its src becomes our dst.
    always_comb begin
        hdr_word = '0;
        hdr_word[HDR_TAG_LSB +: HDR_TAG_W] = hdr_reg[HDR_TAG_LSB +: HDR_TAG_W];
        hdr_word[HDR_CNT_LSB +: HDR_CNT_W] = HDR_CNT_W'(NW);
        hdr_word[HDR_SRC_LSB +: ID_W]      = HsrcId;
        hdr_word[DST_LSB +: ID_W]          = hdr_reg[HDR_SRC_LSB +: ID_W];
    end

    always_ff @(posedge clk_ctrl) begin
        if (clk_ctrl_rst_high) begin
            hdr_reg  <= '0;
            hdr_seen <= 1'b0;
        end else if (header_in_vld) begin
            hdr_reg  <= header_in;
            hdr_seen <= 1'b1;
        end
    end

    // The header word is sampled into TDATA on entry to HDR, so later strobes only affect later packets.
    always_ff @(posedge clk_ctrl) begin
        if (clk_ctrl_rst_high) begin
            state             <= S_IDLE;
            w                 <= '0;
            stream_out_TVALID <= 1'b0;
            stream_out_TDATA  <= '0;
            stream_out_TKEEP  <= '0;
            stream_out_TLAST  <= 1'b0;
            pkt_count         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty && hdr_seen) begin
                        state             <= S_HDR;
                        stream_out_TVALID <= 1'b1;
                        stream_out_TDATA  <= hdr_word;
                        stream_out_TKEEP  <= 4'hF;
                        stream_out_TLAST  <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (stream_out_TREADY) begin
                        state            <= S_DATA;
                        w                <= '0;
                        stream_out_TDATA <= words[0];
                        stream_out_TLAST <= (NW == 1);
                    end
                end
                S_DATA: begin
                    if (stream_out_TREADY) begin
                        if (stream_out_TLAST) begin
                            pkt_count        <= pkt_count + 16'd1;
                            stream_out_TLAST <= 1'b0;
                            if (more) begin
                                state            <= S_HDR;
                                stream_out_TDATA <= hdr_word;
                            end else begin
                                state             <= S_IDLE;
                                stream_out_TVALID <= 1'b0;
                                stream_out_TDATA  <= '0;
                                stream_out_TKEEP  <= '0;
                            end
                        end else begin
                            w                <= w_nxt;
                            stream_out_TDATA <= words[w_nxt];
                            stream_out_TLAST <= (w_nxt == WW'(NW - 1));
                        end
                    end
                end
                default: begin
                    state             <= S_IDLE;
                    stream_out_TVALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asa_resp_framer.sv
// Directed bench for asa_resp_framer with default parameters (XY_SZ=3, RESP_W=64, FIFO_DEPTH=4).
module tb_asa_resp_framer;

    logic        clk;
    logic        rst;
    logic [5:0]  hsrc;
    logic [31:0] header_in;
    logic        header_vld;
    logic        resp_val;
    logic        resp_rdy;
    logic [63:0] resp_msg;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tready;
    logic [15:0] pkt_count;

    int checks   = 0;
    int failures = 0;

    asa_resp_framer dut (
        .clk_ctrl          (clk),
        .clk_ctrl_rst_high (rst),
        .HsrcId            (hsrc),
        .header_in         (header_in),
        .header_in_vld     (header_vld),
        .resp_val          (resp_val),
        .resp_rdy          (resp_rdy),
        .resp_msg          (resp_msg),
        .stream_out_TVALID (tvalid),
        .stream_out_TDATA  (tdata),
        .stream_out_TKEEP  (tkeep),
        .stream_out_TLAST  (tlast),
        .stream_out_TREADY (tready),
        .pkt_count         (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected header words, hand-built as {dst, src, count, tag}.
    localparam logic [31:0] H1_IN  = {6'd0, 6'd5, 12'h00A, 8'h5C};
    localparam logic [31:0] H1_OUT = {6'd5, 6'd9, 12'd2, 8'h5C};   // 32'h1490_025C
    localparam logic [31:0] H2_IN  = {6'd0, 6'd3, 12'd0, 8'h11};
    localparam logic [31:0] H2_OUT = {6'd3, 6'd9, 12'd2, 8'h11};
    localparam logic [31:0] H3_IN  = {6'd0, 6'd7, 12'd0, 8'h33};
    localparam logic [31:0] H3_OUT = {6'd7, 6'd9, 12'd2, 8'h33};
    localparam logic [31:0] H4_IN  = {6'd0, 6'd1, 12'd0, 8'h44};
    localparam logic [31:0] H4_OUT = {6'd1, 6'd9, 12'd2, 8'h44};

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_resp(input logic [63:0] m);
        resp_val = 1'b1;
        resp_msg = m;
        @(negedge clk);
        resp_val = 1'b0;
    endtask

    task automatic strobe_hdr(input logic [31:0] h);
        header_in  = h;
        header_vld = 1'b1;
        @(negedge clk);
        header_vld = 1'b0;
    endtask

    // Waits (bounded) for a handshake and returns the beat; advances past the handshake edge.
    task automatic wait_beat(output logic [31:0] d, output logic l, output int waited, output bit ok);
        ok = 1'b0; waited = 0; d = '0; l = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tvalid === 1'b1 && tready === 1'b1) begin
                d = tdata; l = tlast; ok = 1'b1;
                @(negedge clk);
                break;
            end
            waited++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%0b exp=0", tvalid); end
        checks++; if (tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%0b exp=0", tlast); end
        checks++; if (tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", tdata); end
        checks++; if (tkeep !== 4'h0) begin failures++; $display("FAIL reset_tkeep got=%h exp=0", tkeep); end
        checks++; if (resp_rdy !== 1'b1) begin failures++; $display("FAIL reset_resp_rdy got=%0b exp=1", resp_rdy); end
        checks++; if (pkt_count !== 16'd0) begin failures++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        tready = 1'b1;
        strobe_hdr(H1_IN);
        push_resp(64'hDEAD_BEEF_0123_4567);
        // One edge after the push: still idle.
        checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL basic_lat_early tvalid=%0b exp=0", tvalid); end
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== H1_OUT || tlast !== 1'b0 || tkeep !== 4'hF) begin
            failures++; $display("FAIL basic_hdr v=%0b d=%h l=%0b k=%h exp v=1 d=%h l=0 k=f", tvalid, tdata, tlast, tkeep, H1_OUT);
        end
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h0123_4567 || tlast !== 1'b0 || tkeep !== 4'hF) begin
            failures++; $display("FAIL basic_w0 v=%0b d=%h l=%0b k=%h exp v=1 d=01234567 l=0 k=f", tvalid, tdata, tlast, tkeep);
        end
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== 32'hDEAD_BEEF || tlast !== 1'b1 || tkeep !== 4'hF) begin
            failures++; $display("FAIL basic_w1 v=%0b d=%h l=%0b k=%h exp v=1 d=deadbeef l=1 k=f", tvalid, tdata, tlast, tkeep);
        end
        @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL basic_idle tvalid=%0b exp=0", tvalid); end
        checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL basic_pkt_count got=%0d exp=1", pkt_count); end
    endtask

    task automatic test_no_header_back_to_back();
        logic [31:0] exp_d [6];
        logic        exp_l [6];
        logic [31:0] d;
        logic        l;
        int          waited;
        bit          ok;
        bit          saw_valid;
        do_reset();
        tready = 1'b1;
        push_resp(64'h2222_2222_1111_1111);
        push_resp(64'h4444_4444_3333_3333);
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (tvalid !== 1'b0) saw_valid = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_valid) begin failures++; $display("FAIL nohdr_held tvalid went high without header, exp=0"); end
        exp_d = '{H2_OUT, 32'h1111_1111, 32'h2222_2222, H2_OUT, 32'h3333_3333, 32'h4444_4444};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        strobe_hdr(H2_IN);
        for (int b = 0; b < 6; b++) begin
            wait_beat(d, l, waited, ok);
            checks++;
            if (!ok || d !== exp_d[b] || l !== exp_l[b]) begin
                failures++; $display("FAIL b2b_beat%0d ok=%0b d=%h l=%0b exp d=%h l=%0b", b, ok, d, l, exp_d[b], exp_l[b]);
            end
            if (b > 0) begin
                checks++;
                if (waited !== 0) begin failures++; $display("FAIL b2b_gap%0d idle_cycles=%0d exp=0", b, waited); end
            end
        end
        checks++; if (pkt_count !== 16'd2) begin failures++; $display("FAIL b2b_pkt_count got=%0d exp=2", pkt_count); end
    endtask

    task automatic test_backpressure();
        logic [3:0]  pat = 4'b1001;
        logic [31:0] exp_d [3];
        logic [31:0] got_d [3];
        logic        got_l [3];
        logic [31:0] prev_d;
        logic        prev_l;
        bit          stalled;
        int          nb;
        exp_d = '{H2_OUT, 32'h5555_0000, 32'h5555_FFFF};
        tready = 1'b0;
        push_resp(64'h5555_FFFF_5555_0000);
        stalled = 1'b0; nb = 0; prev_d = '0; prev_l = 1'b0;
        for (int i = 0; i < 40 && nb < 3; i++) begin
            if (stalled) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== prev_d || tlast !== prev_l) begin
                    failures++; $display("FAIL bp_hold cyc%0d v=%0b d=%h l=%0b exp v=1 d=%h l=%0b", i, tvalid, tdata, tlast, prev_d, prev_l);
                end
            end
            tready = pat[i % 4];
            if (tvalid === 1'b1 && tready) begin
                got_d[nb] = tdata; got_l[nb] = tlast; nb++;
            end
            stalled = (tvalid === 1'b1) && !tready;
            prev_d = tdata; prev_l = tlast;
            @(negedge clk);
        end
        checks++; if (nb !== 3) begin failures++; $display("FAIL bp_beats got=%0d exp=3", nb); end
        for (int b = 0; b < nb; b++) begin
            checks++;
            if (got_d[b] !== exp_d[b] || got_l[b] !== (b == 2)) begin
                failures++; $display("FAIL bp_beat%0d d=%h l=%0b exp d=%h l=%0b", b, got_d[b], got_l[b], exp_d[b], (b == 2));
            end
        end
        tready = 1'b1;
        @(negedge clk);
        checks++; if (pkt_count !== 16'd3) begin failures++; $display("FAIL bp_pkt_count got=%0d exp=3", pkt_count); end
    endtask

    task automatic test_fifo_full();
        logic [32:0] beats [$];
        logic [32:0] exp;
        bit          drop;
        bit          accepted;
        int          accepted_at;
        tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            resp_val = 1'b1;
            resp_msg = {32'hB000_0000 + 32'(k), 32'hA000_0000 + 32'(k)};
            checks++;
            if (resp_rdy !== (k < 4)) begin failures++; $display("FAIL full_rdy%0d got=%0b exp=%0b", k, resp_rdy, (k < 4)); end
            if (k < 4) @(negedge clk);
        end
        tready = 1'b1;
        accepted = 1'b0; accepted_at = -1;
        for (int c = 0; c < 200 && beats.size() < 15; c++) begin
            if (tvalid === 1'b1) beats.push_back({tlast, tdata});
            drop = resp_val && resp_rdy;
            @(negedge clk);
            if (drop) begin resp_val = 1'b0; accepted = 1'b1; accepted_at = beats.size(); end
        end
        resp_val = 1'b0;
        checks++; if (beats.size() !== 15) begin failures++; $display("FAIL full_beats got=%0d exp=15", beats.size()); end
        checks++;
        if (!accepted || accepted_at < 3) begin failures++; $display("FAIL full_fifth_accept accepted=%0b after_beat=%0d exp accepted after beat>=3", accepted, accepted_at); end
        for (int b = 0; b < beats.size() && b < 15; b++) begin
            case (b % 3)
                0:       exp = {1'b0, H2_OUT};
                1:       exp = {1'b0, 32'hA000_0000 + 32'(b / 3)};
                default: exp = {1'b1, 32'hB000_0000 + 32'(b / 3)};
            endcase
            checks++;
            if (beats[b] !== exp) begin failures++; $display("FAIL full_beat%0d got=%h exp=%h", b, beats[b], exp); end
        end
        @(negedge clk);
        checks++; if (pkt_count !== 16'd8) begin failures++; $display("FAIL full_pkt_count got=%0d exp=8", pkt_count); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        l;
        int          waited;
        bit          ok;
        bit          saw_valid;
        logic [31:0] exp_d [3];
        tready = 1'b1;
        push_resp(64'h7777_7777_6666_6666);
        wait_beat(d, l, waited, ok);
        wait_beat(d, l, waited, ok);
        checks++;
        if (!ok || d !== 32'h6666_6666) begin failures++; $display("FAIL rmid_first_word ok=%0b d=%h exp=66666666", ok, d); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL rmid_tvalid got=%0b exp=0", tvalid); end
        checks++; if (tlast !== 1'b0) begin failures++; $display("FAIL rmid_tlast got=%0b exp=0", tlast); end
        checks++; if (pkt_count !== 16'd0) begin failures++; $display("FAIL rmid_pkt_count got=%0d exp=0", pkt_count); end
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (tvalid !== 1'b0) saw_valid = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_valid) begin failures++; $display("FAIL rmid_discard tvalid went high after reset, exp=0"); end
        strobe_hdr(H3_IN);
        push_resp(64'h9999_9999_8888_8888);
        exp_d = '{H3_OUT, 32'h8888_8888, 32'h9999_9999};
        for (int b = 0; b < 3; b++) begin
            wait_beat(d, l, waited, ok);
            checks++;
            if (!ok || d !== exp_d[b] || l !== (b == 2)) begin
                failures++; $display("FAIL rmid_beat%0d ok=%0b d=%h l=%0b exp d=%h l=%0b", b, ok, d, l, exp_d[b], (b == 2));
            end
        end
        checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL rmid_pkt_count_after got=%0d exp=1", pkt_count); end
    endtask

    task automatic test_hdr_change();
        logic [31:0] d;
        logic        l;
        int          waited;
        bit          ok;
        tready = 1'b0;
        push_resp(64'hBBBB_0001_AAAA_0001);
        push_resp(64'hBBBB_0002_AAAA_0002);
        tready = 1'b1;
        wait_beat(d, l, waited, ok);
        checks++; if (!ok || d !== H3_OUT) begin failures++; $display("FAIL hchg_hdr1 ok=%0b d=%h exp=%h", ok, d, H3_OUT); end
        header_in  = H4_IN;
        header_vld = 1'b1;
        wait_beat(d, l, waited, ok);
        header_vld = 1'b0;
        checks++; if (!ok || d !== 32'hAAAA_0001) begin failures++; $display("FAIL hchg_w0 ok=%0b d=%h exp=aaaa0001", ok, d); end
        wait_beat(d, l, waited, ok);
        checks++; if (!ok || d !== 32'hBBBB_0001 || l !== 1'b1) begin failures++; $display("FAIL hchg_w1 ok=%0b d=%h l=%0b exp d=bbbb0001 l=1", ok, d, l); end
        wait_beat(d, l, waited, ok);
        checks++; if (!ok || d !== H4_OUT || l !== 1'b0) begin failures++; $display("FAIL hchg_hdr2 ok=%0b d=%h l=%0b exp d=%h l=0", ok, d, l, H4_OUT); end
        wait_beat(d, l, waited, ok);
        wait_beat(d, l, waited, ok);
        checks++; if (!ok || d !== 32'hBBBB_0002 || l !== 1'b1) begin failures++; $display("FAIL hchg_p2_last ok=%0b d=%h l=%0b exp d=bbbb0002 l=1", ok, d, l); end
        checks++; if (pkt_count !== 16'd3) begin failures++; $display("FAIL hchg_pkt_count got=%0d exp=3", pkt_count); end
    endtask

    initial begin
        rst        = 1'b1;
        hsrc       = 6'h09;
        header_in  = '0;
        header_vld = 1'b0;
        resp_val   = 1'b0;
        resp_msg   = '0;
        tready     = 1'b0;
        test_reset();
        test_basic();
        test_no_header_back_to_back();
        test_backpressure();
        test_fifo_full();
        test_reset_mid();
        test_hdr_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
